change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream of the purchase controller. Consumes the refund amount in cents and a start strobe, which is driven from the purchase-accepted flag.
- Drives the coin-return mechanism one coin at a time over a valid/ack handshake, choosing coins greedily: dollar, quarter, dime, nickel.
- Reports completion, any undispensable remainder, and a mechanism timeout.

Parameters:
- AMT_W, 12, width of amount and residue in cents.
- ACK_TIMEOUT, 1000, maximum cycles coin_valid may wait for coin_ack.
- INV_INIT, 20, per-denomination coin count loaded at reset and on restock. Used only with CHANGE_INVENTORY_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; amount is sampled on this cycle.
- amount  in  AMT_W  refund in cents.
- busy  out  1  high from the cycle after an accepted start until done.
- coin_valid  out  1  request to eject the coin on coin_sel.
- coin_sel  out  2  coin to eject: 00 nickel (5), 01 dime (10), 10 quarter (25), 11 dollar (100).
- coin_ack  in  1  mechanism accepted the coin; sampled only while coin_valid=1.
- done  out  1  one-cycle completion pulse.
- residue  out  AMT_W  cents not dispensed; valid from done until the next accepted start.
- timeout_err  out  1  sticky; cleared by the next accepted start.
- restock  in  1  with CHANGE_INVENTORY_EN only: reload all counts to INV_INIT.

Behaviour:
- Reset values: busy=0, coin_valid=0, coin_sel=00, done=0, residue=0, timeout_err=0, remaining=0, state=IDLE.
- Reset mid-operation: the FSM returns to IDLE at that edge and any in-flight coin is abandoned (coin_valid=0 after the edge).
- IDLE: start=1 latches remaining<=amount, clears residue and timeout_err, and moves to SELECT. start while not IDLE is ignored.
- SELECT: pick the largest coin with value <= remaining.
  - If one exists: coin_sel<=code, coin_valid<=1, clear the timer, go to WAIT_ACK.
  - If none (remaining<5): residue<=remaining, go to DONE.
  - Timing: start at edge N gives coin_valid high after edge N+2.
- WAIT_ACK: coin_valid and coin_sel are held stable.
  - coin_ack=1: remaining<=remaining-value, coin_valid<=0, go to GAP.
  - Otherwise the timer increments. When timer reaches ACK_TIMEOUT-1 with no ack: coin_valid<=0, timeout_err<=1, residue<=remaining, go to DONE.
  - An ack arriving on the same cycle as the final timer count wins; no timeout is raised.
- GAP: one cycle with coin_valid low, then SELECT. This guarantees at least one low cycle between coins.
- DONE: done=1 for exactly one cycle, busy<=0, go to IDLE.
- amount=0: SELECT finds no coin, so done pulses 2 cycles after start with residue 0 and no coin issued.
- Arithmetic: unsigned; subtraction never underflows by construction. A coin_ack received outside WAIT_ACK is ignored.

Optional Feature:
- Macro: CHANGE_INVENTORY_EN.
- Defined:
  - Four counters of width clog2(INV_INIT+1)+1 are loaded to INV_INIT on reset or restock.
  - SELECT skips any denomination whose count is 0.
  - Each accepted coin decrements its counter.
  - restock during busy is deferred until IDLE.
  - Exhausting coins leaves a larger residue but is not an error.
- Undefined: the restock port and counters are absent, and all denominations are unlimited.

Decomposition:
- Shared package vend_pkg:
  - coin code constants COIN_NICKEL/DIME/QUARTER/DOLLAR.
  - value constants 5/10/25/100.
  - AMT_W default.
  - the state enum IDLE/SELECT/WAIT_ACK/GAP/DONE.
- One combinational sub-module, coin_selector:
  - inputs: remaining, availability mask.
  - outputs: found, coin code, coin value.
  - The FSM and timer stay in change_dispenser.

Test Plan:
- amount=65, ack 1 cycle after each valid -> quarter, quarter, dime, nickel; done; residue=0; timeout_err=0.
- amount=187 -> dollar, quarter x3, dime; residue=2.
- amount=0 -> no coin_valid; done 2 cycles after start; residue=0.
- amount=25, coin_ack held low -> coin_valid high for exactly 1000 cycles, then timeout_err=1, residue=25, done pulse. Next start clears timeout_err.
- Second start during busy with amount=100 -> ignored; first transaction completes unchanged. reset asserted in WAIT_ACK -> coin_valid=0 and busy=0 after the edge.
- CHANGE_INVENTORY_EN with INV_INIT=1, amount=60 -> quarter, dime, nickel; residue=20. Restock, then amount=60 again -> same sequence.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values,
// default amount width and the dispenser FSM state type.
// Optional feature macro used by dependants: CHANGE_INVENTORY_EN.
package vend_pkg;

  localparam int unsigned DEF_AMT_W = 12;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NICKEL  = 2'b00;
  localparam coin_code_t COIN_DIME    = 2'b01;
  localparam coin_code_t COIN_QUARTER = 2'b10;
  localparam coin_code_t COIN_DOLLAR  = 2'b11;

  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;
  localparam int unsigned VAL_DOLLAR  = 100;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_ACK,
    GAP,
    DONE
  } state_e;

  // Value in cents of a coin code.
  function automatic int unsigned coin_value(coin_code_t code);
    int unsigned val;
    unique case (code)
      COIN_NICKEL:  val = VAL_NICKEL;
      COIN_DIME:    val = VAL_DIME;
      COIN_QUARTER: val = VAL_QUARTER;
      default:      val = VAL_DOLLAR;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin-return handshake between the change dispenser (master) and the
// coin-return mechanism (slave).
//   coin_valid : request to eject the coin on coin_sel
//   coin_sel   : coin code (see vend_pkg)
//   coin_ack   : mechanism accepted the coin
interface change_dispenser_if;

  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       coin_ack;

  modport master (
    output coin_valid,
    output coin_sel,
    input  coin_ack
  );

  modport slave (
    input  coin_valid,
    input  coin_sel,
    output coin_ack
  );

endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Combinational greedy coin picker: largest available coin whose value does
// not exceed the remaining amount (dollar, quarter, dime, nickel).
//   remaining_i : cents still owed
//   avail_i     : availability mask indexed by coin code
//   found_o     : a coin could be chosen
//   code_o      : chosen coin code
//   value_o     : chosen coin value in cents
module coin_selector
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = DEF_AMT_W
) (
  input  logic [AMT_W-1:0] remaining_i,
  input  logic [3:0]       avail_i,
  output logic             found_o,
  output coin_code_t       code_o,
  output logic [AMT_W-1:0] value_o
);

  always_comb begin
    found_o = 1'b0;
    code_o  = COIN_NICKEL;
    value_o = '0;
    if (avail_i[COIN_DOLLAR] && remaining_i >= AMT_W'(VAL_DOLLAR)) begin
      found_o = 1'b1;
      code_o  = COIN_DOLLAR;
      value_o = AMT_W'(VAL_DOLLAR);
    end else if (avail_i[COIN_QUARTER] && remaining_i >= AMT_W'(VAL_QUARTER)) begin
      found_o = 1'b1;
      code_o  = COIN_QUARTER;
      value_o = AMT_W'(VAL_QUARTER);
    end else if (avail_i[COIN_DIME] && remaining_i >= AMT_W'(VAL_DIME)) begin
      found_o = 1'b1;
      code_o  = COIN_DIME;
      value_o = AMT_W'(VAL_DIME);
    end else if (avail_i[COIN_NICKEL] && remaining_i >= AMT_W'(VAL_NICKEL)) begin
      found_o = 1'b1;
      code_o  = COIN_NICKEL;
      value_o = AMT_W'(VAL_NICKEL);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a refund one coin at a time over a valid/ack
// handshake, greedy by denomination, and reports residue and ack timeouts.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start/amount : one-cycle request and refund in cents (sampled with start)
//   busy         : transaction in progress
//   coin         : coin-return handshake (master side)
//   done         : one-cycle completion pulse
//   residue      : cents not dispensed, valid from done to next start
//   timeout_err  : sticky mechanism timeout, cleared by next start
//   restock      : reload coin inventory (only with CHANGE_INVENTORY_EN)
// Optional feature macro: CHANGE_INVENTORY_EN (finite per-coin inventory).
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W       = DEF_AMT_W,
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned INV_INIT    = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  change_dispenser_if.master coin,
  output logic             done,
  output logic [AMT_W-1:0] residue,
  output logic             timeout_err
`ifdef CHANGE_INVENTORY_EN
  ,
  input  logic             restock
`endif
);

  localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] residue_q, residue_d;
  logic             terr_q, terr_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  coin_code_t       sel_q, sel_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             found;
  coin_code_t       pick_code;
  logic [AMT_W-1:0] pick_value;
  logic [3:0]       avail;
  logic             accept;

  // A coin leaves the machine only on an ack while waiting for it.
  assign accept = (state_q == WAIT_ACK) && coin.coin_ack;

`ifdef CHANGE_INVENTORY_EN
  localparam int unsigned INV_W = $clog2(INV_INIT + 1) + 1;

  logic [3:0][INV_W-1:0] inv_q, inv_d;
  logic                  restock_pend_q, restock_pend_d;

  always_comb begin
    inv_d          = inv_q;
    restock_pend_d = restock_pend_q | restock;
    for (int i = 0; i < 4; i++) avail[i] = (inv_q[i] != '0);
    if (state_q == IDLE && restock_pend_d) begin
      for (int i = 0; i < 4; i++) inv_d[i] = INV_W'(INV_INIT);
      restock_pend_d = 1'b0;
    end else if (accept) begin
      inv_d[sel_q] = inv_q[sel_q] - INV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) inv_q[i] <= INV_W'(INV_INIT);
      restock_pend_q <= 1'b0;
    end else begin
      inv_q          <= inv_d;
      restock_pend_q <= restock_pend_d;
    end
  end
`else
  assign avail = 4'b1111;
`endif

  coin_selector #(
    .AMT_W (AMT_W)
  ) u_coin_selector (
    .remaining_i (remaining_q),
    .avail_i     (avail),
    .found_o     (found),
    .code_o      (pick_code),
    .value_o     (pick_value)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    residue_d   = residue_q;
    terr_d      = terr_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = amount;
          residue_d   = '0;
          terr_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          sel_d   = pick_code;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = WAIT_ACK;
        end else begin
          residue_d = remaining_q;
          state_d   = DONE;
        end
      end
      WAIT_ACK: begin
        // Ack on the final timer count still wins over the timeout.
        if (coin.coin_ack) begin
          remaining_d = remaining_q - AMT_W'(coin_value(sel_q));
          valid_d     = 1'b0;
          state_d     = GAP;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          valid_d   = 1'b0;
          terr_d    = 1'b1;
          residue_d = remaining_q;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: state_d = SELECT;
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      residue_q   <= '0;
      terr_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sel_q       <= COIN_NICKEL;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residue_q   <= residue_d;
      terr_q      <= terr_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
    end
  end

  assign busy            = busy_q;
  assign done            = (state_q == DONE);
  assign residue         = residue_q;
  assign timeout_err     = terr_q;
  assign coin.coin_valid = valid_q;
  assign coin.coin_sel   = sel_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int unsigned AW = 12;
`ifdef CHANGE_INVENTORY_EN
  localparam int unsigned TB_INV = 1;
`else
  localparam int unsigned TB_INV = 20;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] amount;
  logic          busy;
  logic          done;
  logic [AW-1:0] residue;
  logic          timeout_err;
  logic          restock;

  change_dispenser_if cif ();

  change_dispenser #(
    .AMT_W       (AW),
    .ACK_TIMEOUT (1000),
    .INV_INIT    (TB_INV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount      (amount),
    .busy        (busy),
    .coin        (cif),
    .done        (done),
    .residue     (residue),
    .timeout_err (timeout_err)
`ifdef CHANGE_INVENTORY_EN
    ,
    .restock     (restock)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [1:0]    sel_log [16];
  int            ncoin;
  int            done_cyc;
  int            first_valid;
  int            valid_total;
  logic [AW-1:0] res_seen;
  logic          terr_seen;
  bit            sel_stable;

  // Issue one request and act as the coin mechanism until done (bounded).
  // Cycle 0 is the first sample after the edge that accepted start.
  task automatic run_txn(input logic [AW-1:0] amt, input bit ack_en, input int ign_cyc);
    int         vcnt;
    logic [1:0] held;
    vcnt        = 0;
    held        = 2'b00;
    ncoin       = 0;
    done_cyc    = -1;
    first_valid = -1;
    valid_total = 0;
    sel_stable  = 1'b1;
    res_seen    = 'x;
    terr_seen   = 1'bx;
    @(posedge clk); #1;
    start  = 1'b1;
    amount = amt;
    @(posedge clk); #1;
    start  = 1'b0;
    amount = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == ign_cyc) begin
        start  = 1'b1;
        amount = AW'(100);
      end else begin
        start  = 1'b0;
        amount = '0;
      end
      if (cif.coin_valid) begin
        vcnt++;
        valid_total++;
        if (vcnt == 1) begin
          if (first_valid < 0) first_valid = cyc;
          if (ncoin < 16) sel_log[ncoin] = cif.coin_sel;
          ncoin++;
          held = cif.coin_sel;
        end else if (cif.coin_sel !== held) begin
          sel_stable = 1'b0;
        end
      end else begin
        vcnt = 0;
      end
      cif.coin_ack = ack_en && (vcnt == 2);
      if (done) begin
        done_cyc  = cyc;
        res_seen  = residue;
        terr_seen = timeout_err;
        break;
      end
      @(posedge clk); #1;
    end
    start        = 1'b0;
    amount       = '0;
    cif.coin_ack = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    amount       = '0;
    restock      = 1'b0;
    cif.coin_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(cif.coin_valid), 32'd0);
    check("rst_sel", 32'(cif.coin_sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_residue", 32'(residue), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    reset = 1'b0;

`ifndef CHANGE_INVENTORY_EN
    // 65 = Q + Q + D + N
    run_txn(AW'(65), 1'b1, -1);
    check("a65_ncoin", 32'(ncoin), 32'd4);
    check("a65_c0", 32'(sel_log[0]), 32'd2);
    check("a65_c1", 32'(sel_log[1]), 32'd2);
    check("a65_c2", 32'(sel_log[2]), 32'd1);
    check("a65_c3", 32'(sel_log[3]), 32'd0);
    check("a65_first_valid", 32'(first_valid), 32'd1);
    check("a65_done_cyc", 32'(done_cyc), 32'd17);
    check("a65_residue", 32'(res_seen), 32'd0);
    check("a65_terr", 32'(terr_seen), 32'd0);
    check("a65_busy_in_done", 32'(busy), 32'd1);
    check("a65_sel_stable", 32'(sel_stable), 32'd1);
    @(posedge clk); #1;
    check("a65_busy_after", 32'(busy), 32'd0);
    check("a65_done_after", 32'(done), 32'd0);

    // 187 = $ + Q + Q + Q + D, residue 2
    run_txn(AW'(187), 1'b1, -1);
    check("a187_ncoin", 32'(ncoin), 32'd5);
    check("a187_c0", 32'(sel_log[0]), 32'd3);
    check("a187_c1", 32'(sel_log[1]), 32'd2);
    check("a187_c2", 32'(sel_log[2]), 32'd2);
    check("a187_c3", 32'(sel_log[3]), 32'd2);
    check("a187_c4", 32'(sel_log[4]), 32'd1);
    check("a187_residue", 32'(res_seen), 32'd2);

    // Zero amount: no coin, done two cycles after start
    run_txn(AW'(0), 1'b1, -1);
    check("a0_valid_total", 32'(valid_total), 32'd0);
    check("a0_done_cyc", 32'(done_cyc), 32'd1);
    check("a0_residue", 32'(res_seen), 32'd0);

    // Mechanism never acks: 1000 valid cycles then timeout
    run_txn(AW'(25), 1'b0, -1);
    check("to_valid_total", 32'(valid_total), 32'd1000);
    check("to_sel", 32'(sel_log[0]), 32'd2);
    check("to_done_cyc", 32'(done_cyc), 32'd1001);
    check("to_terr", 32'(terr_seen), 32'd1);
    check("to_residue", 32'(res_seen), 32'd25);
    repeat (3) @(posedge clk);
    #1;
    check("to_terr_sticky", 32'(timeout_err), 32'd1);
    check("to_valid_low", 32'(cif.coin_valid), 32'd0);

    // Next start clears the sticky error
    run_txn(AW'(10), 1'b1, -1);
    check("clr_terr", 32'(terr_seen), 32'd0);
    check("clr_ncoin", 32'(ncoin), 32'd1);
    check("clr_sel", 32'(sel_log[0]), 32'd1);
    check("clr_residue", 32'(res_seen), 32'd0);

    // Start with amount 100 while busy (in GAP) is ignored
    run_txn(AW'(65), 1'b1, 3);
    check("ign_ncoin", 32'(ncoin), 32'd4);
    check("ign_c0", 32'(sel_log[0]), 32'd2);
    check("ign_c3", 32'(sel_log[3]), 32'd0);
    check("ign_done_cyc", 32'(done_cyc), 32'd17);
    check("ign_residue", 32'(res_seen), 32'd0);
    @(posedge clk); #1;
    check("ign_idle_busy", 32'(busy), 32'd0);
`else
    // One coin of each kind: 60 = Q + D + N, residue 20
    run_txn(AW'(60), 1'b1, -1);
    check("inv1_ncoin", 32'(ncoin), 32'd3);
    check("inv1_c0", 32'(sel_log[0]), 32'd2);
    check("inv1_c1", 32'(sel_log[1]), 32'd1);
    check("inv1_c2", 32'(sel_log[2]), 32'd0);
    check("inv1_residue", 32'(res_seen), 32'd20);
    check("inv1_terr", 32'(terr_seen), 32'd0);

    // Inventory exhausted: nothing paid out
    run_txn(AW'(60), 1'b1, -1);
    check("inv2_valid_total", 32'(valid_total), 32'd0);
    check("inv2_done_cyc", 32'(done_cyc), 32'd1);
    check("inv2_residue", 32'(res_seen), 32'd60);

    @(posedge clk); #1;
    restock = 1'b1;
    @(posedge clk); #1;
    restock = 1'b0;

    run_txn(AW'(60), 1'b1, -1);
    check("inv3_ncoin", 32'(ncoin), 32'd3);
    check("inv3_c0", 32'(sel_log[0]), 32'd2);
    check("inv3_c1", 32'(sel_log[1]), 32'd1);
    check("inv3_c2", 32'(sel_log[2]), 32'd0);
    check("inv3_residue", 32'(res_seen), 32'd20);
    @(posedge clk); #1;
    restock = 1'b1;
    @(posedge clk); #1;
    restock = 1'b0;
`endif

    // Reset while waiting for ack abandons the coin
    @(posedge clk); #1;
    start  = 1'b1;
    amount = AW'(25);
    @(posedge clk); #1;
    start  = 1'b0;
    amount = '0;
    @(posedge clk); #1;
    check("rw_valid_before", 32'(cif.coin_valid), 32'd1);
    check("rw_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rw_valid_after", 32'(cif.coin_valid), 32'd0);
    check("rw_busy_after", 32'(busy), 32'd0);
    check("rw_done_after", 32'(done), 32'd0);
    reset = 1'b0;

    // Normal operation resumes after reset
    run_txn(AW'(5), 1'b1, -1);
    check("post_ncoin", 32'(ncoin), 32'd1);
    check("post_sel", 32'(sel_log[0]), 32'd0);
    check("post_residue", 32'(res_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
